// File: rtl/rle_block_sched_if.sv
// Bus bundle between the RLE block scheduler and its neighbours: the
// quantiser/zig-zag coefficient buffers on one side and ac_rle on the other.
// The master modport is the scheduler's view; slave is the environment's view.
interface rle_block_sched_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 6
);
  logic                   mode420_i;
  logic [2:0]             blk_req_i;
  logic [3*LEN_W-1:0]     blk_len_i;
  logic [2:0]             blk_ack_o;
  logic                   dn_ready_i;
  logic                   buf_rd_o;
  logic [1:0]             buf_sel_o;
  logic [5:0]             buf_addr_o;
  logic [DATA_W-1:0]      buf_data_i;
  logic                   rle_data_go_o;
  logic [DATA_W-1:0]      rle_data_o;
  logic [LEN_W-1:0]       rle_len_o;
  logic [1:0]             comp_id_o;
  logic                   rle_last_i;
  logic                   mcu_done_o;
  logic                   busy_o;
  logic                   err_o;

  modport master (
    input  mode420_i, blk_req_i, blk_len_i, dn_ready_i, buf_data_i, rle_last_i,
    output blk_ack_o, buf_rd_o, buf_sel_o, buf_addr_o, rle_data_go_o, rle_data_o,
           rle_len_o, comp_id_o, mcu_done_o, busy_o, err_o
  );

  modport slave (
    output mode420_i, blk_req_i, blk_len_i, dn_ready_i, buf_data_i, rle_last_i,
    input  blk_ack_o, buf_rd_o, buf_sel_o, buf_addr_o, rle_data_go_o, rle_data_o,
           rle_len_o, comp_id_o, mcu_done_o, busy_o, err_o
  );
endinterface

// File: rtl/rle_block_sched.sv
// Block scheduler for the AC run-length encoder stage.
// Serves Y/Cb/Cr coefficient buffers in fixed JPEG MCU order, streams one
// 8x8 block (go pulse, length, 64 zig-zag coefficients) into the RLE and
// acks the source buffer once the RLE signals end-of-block.
// Optional feature macro: SCHED_420_EN (adds the 6-slot 4:2:0 MCU table,
// selected by mode420_i). Without it the order is fixed 4:4:4.
module rle_block_sched #(
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 6,
  parameter int BLK_SIZE  = 64,
  parameter int DRAIN_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  rle_block_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    GO     = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    ACK    = 3'd5
  } state_e;

`ifdef SCHED_420_EN
  localparam int SLOT_W = 3;
`else
  localparam int SLOT_W = 2;
`endif

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [6:0]        cnt_q, cnt_d;      // read address in GO/STREAM, wait count in DRAIN
  logic [1:0]        comp_q, comp_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic              vld_q;             // buffer read issued last cycle -> data valid now
  logic [1:0]        slot_comp;
  logic              last_slot;
  logic              rd, go, ack, done;

`ifdef SCHED_420_EN
  logic mode_q;

  // Capture the MCU format only at the start of an MCU so a change mid-MCU waits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                mode_q <= 1'b0;
    else if (state_q == WAIT && slot_q == '0) mode_q <= bus.mode420_i;
  end

  // Map the slot number to a component for the active MCU format.
  always_comb begin
    slot_comp = slot_q[1:0];
    last_slot = (slot_q == 3'd2);
    if (mode_q) begin
      last_slot = (slot_q == 3'd5);
      case (slot_q)
        3'd4:    slot_comp = 2'd1;
        3'd5:    slot_comp = 2'd2;
        default: slot_comp = 2'd0;
      endcase
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode420_i;

  // In 4:4:4 the slot number is the component number.
  always_comb begin
    slot_comp = slot_q;
    last_slot = (slot_q == 2'd2);
  end
`endif

  // State and datapath registers; reset aborts any block without acking it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      comp_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
      len_q   <= len_d;
      err_q   <= err_d;
      vld_q   <= rd;
    end
  end

  // Next-state logic and per-state strobes.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    comp_d  = comp_q;
    len_d   = len_q;
    err_d   = err_q;
    rd      = 1'b0;
    go      = 1'b0;
    ack     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.blk_req_i) state_d = WAIT;
      end
      WAIT: begin
        if (bus.blk_req_i[slot_comp] && bus.dn_ready_i) begin
          state_d = GO;
          comp_d  = slot_comp;
          len_d   = bus.blk_len_i[slot_comp*LEN_W +: LEN_W];
          cnt_d   = '0;
        end
      end
      GO: begin
        go      = 1'b1;
        rd      = 1'b1;
        cnt_d   = 7'd1;
        state_d = STREAM;
      end
      STREAM: begin
        rd = 1'b1;
        if (cnt_q == 7'(BLK_SIZE - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      DRAIN: begin
        if (bus.rle_last_i) begin
          cnt_d   = '0;
          state_d = ACK;
        end else if (cnt_q == 7'(DRAIN_MAX - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ACK: begin
        ack     = 1'b1;
        done    = last_slot;
        slot_d  = last_slot ? '0 : slot_q + 1'b1;
        state_d = (|bus.blk_req_i) ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rle_data_go_o = go;
  assign bus.buf_rd_o      = rd;
  assign bus.buf_sel_o     = comp_q;
  assign bus.buf_addr_o    = rd ? cnt_q[5:0] : 6'd0;
  assign bus.rle_data_o    = vld_q ? bus.buf_data_i : '0;
  assign bus.rle_len_o     = len_q;
  assign bus.comp_id_o     = comp_q;
  assign bus.blk_ack_o     = ack ? (3'b001 << comp_q) : 3'b000;
  assign bus.mcu_done_o    = done;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_rle_block_sched.sv
// Self-checking bench for rle_block_sched: a behavioural coefficient buffer,
// per-component requesters and a queue of expected blocks in MCU order.
module tb_rle_block_sched;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 6;
  localparam int BLK_SIZE  = 64;
  localparam int DRAIN_MAX = 8;

  typedef struct packed {
    logic [1:0]       comp;
    logic [LEN_W-1:0] len;
    logic             done;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rle_block_sched_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  rle_block_sched #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .BLK_SIZE(BLK_SIZE), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  blk_t exp_q[$];
  int   pend[3];
  logic [LEN_W-1:0] len_cfg[3];
  bit   err_exp = 1'b0;

  function automatic logic [DATA_W-1:0] coeff(input logic [1:0] c, input logic [5:0] k);
    return 16'h1000 * (16'(c) + 16'd1) + 16'(k) * 16'd3 + 16'd1;
  endfunction

  // Coefficient buffer: data one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (bus.buf_rd_o) bus.buf_data_i <= coeff(bus.buf_sel_o, bus.buf_addr_o);
    else              bus.buf_data_i <= 16'hDEAD;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_req();
    for (int c = 0; c < 3; c++) bus.blk_req_i[c] = (pend[c] > 0);
    bus.blk_len_i = {len_cfg[2], len_cfg[1], len_cfg[0]};
  endtask

  task automatic push_blk(input logic [1:0] c, input logic d);
    blk_t e;
    e.comp = c;
    e.len  = len_cfg[c];
    e.done = d;
    exp_q.push_back(e);
  endtask

  // Pops the next expected block and follows it from go to ack.
  // last_delay < 0 means rle_last_i is never raised (timeout path).
  task automatic serve_block(input int last_delay, input bit at_go);
    blk_t e;
    bit   seen;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL scoreboard_empty: no expected block queued");
      return;
    end
    e    = exp_q.pop_front();
    seen = at_go && bus.rle_data_go_o;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.rle_data_go_o) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL go_timeout: no rle_data_go_o for comp %0d", e.comp);
      return;
    end
    tests_run++;
    if (bus.comp_id_o !== e.comp) begin
      tests_failed++;
      $display("FAIL go_comp: got %0d expected %0d", bus.comp_id_o, e.comp);
    end
    tests_run++;
    if (bus.rle_len_o !== e.len) begin
      tests_failed++;
      $display("FAIL go_len: got %0d expected %0d", bus.rle_len_o, e.len);
    end
    tests_run++;
    if (bus.buf_rd_o !== 1'b1 || bus.buf_addr_o !== 6'd0 || bus.rle_data_o !== '0) begin
      tests_failed++;
      $display("FAIL go_read: rd=%b addr=%0d data=%h expected rd=1 addr=0 data=0",
               bus.buf_rd_o, bus.buf_addr_o, bus.rle_data_o);
    end
    for (int k = 0; k < BLK_SIZE; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.rle_data_o !== coeff(e.comp, 6'(k))) begin
        tests_failed++;
        $display("FAIL coeff_%0d: got %h expected %h", k, bus.rle_data_o, coeff(e.comp, 6'(k)));
      end
    end
    if (last_delay >= 0) begin
      repeat (last_delay) @(negedge clk);
      bus.rle_last_i = 1'b1;
      @(negedge clk);
      bus.rle_last_i = 1'b0;
    end else begin
      repeat (DRAIN_MAX - 1) @(negedge clk);
      tests_run++;
      if (bus.blk_ack_o !== 3'b000) begin
        tests_failed++;
        $display("FAIL early_ack: got %b expected 000", bus.blk_ack_o);
      end
      @(negedge clk);
      err_exp = 1'b1;
    end
    tests_run++;
    if (bus.blk_ack_o !== (3'b001 << e.comp)) begin
      tests_failed++;
      $display("FAIL ack: got %b expected %b", bus.blk_ack_o, 3'b001 << e.comp);
    end
    tests_run++;
    if (bus.mcu_done_o !== e.done) begin
      tests_failed++;
      $display("FAIL mcu_done: got %b expected %b", bus.mcu_done_o, e.done);
    end
    tests_run++;
    if (bus.err_o !== err_exp || bus.rle_data_o !== '0 || bus.rle_len_o !== e.len) begin
      tests_failed++;
      $display("FAIL ack_state: err=%b data=%h len=%0d expected err=%b data=0 len=%0d",
               bus.err_o, bus.rle_data_o, bus.rle_len_o, err_exp, e.len);
    end
    pend[e.comp]--;
    drive_req();
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    tests_run++;
    if (bus.busy_o !== 1'b0 || bus.blk_ack_o !== 3'b000 || bus.mcu_done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: busy=%b ack=%b done=%b expected 0,000,0",
               name, bus.busy_o, bus.blk_ack_o, bus.mcu_done_o);
    end
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    repeat (3) @(negedge clk);
    outs = {bus.blk_ack_o, bus.buf_rd_o, bus.buf_sel_o, bus.buf_addr_o, bus.rle_data_go_o,
            bus.rle_data_o, bus.rle_len_o, bus.comp_id_o, bus.mcu_done_o, bus.busy_o,
            bus.err_o, 21'd0};
    tests_run++;
    if (outs !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
  endtask

  task automatic test_mcu_444();
    len_cfg[0] = 6'd5; len_cfg[1] = 6'd17; len_cfg[2] = 6'd40;
    pend[0] = 1; pend[1] = 1; pend[2] = 1;
    push_blk(2'd0, 1'b0); push_blk(2'd1, 1'b0); push_blk(2'd2, 1'b1);
    drive_req();
    for (int b = 0; b < 3; b++) serve_block(2, 1'b0);
    expect_idle("idle_after_444");
  endtask

`ifdef SCHED_420_EN
  task automatic test_mcu_420();
    bit go_seen = 1'b0;
    bit idle_seen = 1'b0;
    bus.mode420_i = 1'b1;
    pend[1] = 1;
    drive_req();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rle_data_go_o) go_seen = 1'b1;
      if (!bus.busy_o) idle_seen = 1'b1;
    end
    tests_run++;
    if (go_seen || idle_seen) begin
      tests_failed++;
      $display("FAIL cb_only_wait: go_seen=%b idle_seen=%b expected 0,0", go_seen, idle_seen);
    end
    pend[0] = 4; pend[2] = 1;
    for (int b = 0; b < 4; b++) push_blk(2'd0, 1'b0);
    push_blk(2'd1, 1'b0); push_blk(2'd2, 1'b1);
    drive_req();
    for (int b = 0; b < 6; b++) serve_block(0, 1'b0);
    bus.mode420_i = 1'b0;
    expect_idle("idle_after_420");
  endtask
`endif

  task automatic test_ready_stall();
    bit go_seen = 1'b0;
    bit idle_seen = 1'b0;
    bus.dn_ready_i = 1'b0;
    pend[0] = 1;
    push_blk(2'd0, 1'b0);
    drive_req();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rle_data_go_o) go_seen = 1'b1;
      if (!bus.busy_o) idle_seen = 1'b1;
    end
    tests_run++;
    if (go_seen || idle_seen) begin
      tests_failed++;
      $display("FAIL ready_stall: go_seen=%b idle_seen=%b expected 0,0", go_seen, idle_seen);
    end
    bus.dn_ready_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.rle_data_go_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL go_after_ready: got %b expected 1", bus.rle_data_go_o);
    end
    serve_block(1, 1'b1);
  endtask

  task automatic test_drain_timeout();
    pend[1] = 1;
    push_blk(2'd1, 1'b0);
    drive_req();
    serve_block(-1, 1'b0);
    pend[2] = 1;
    push_blk(2'd2, 1'b1);
    drive_req();
    serve_block(1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (bus.err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b expected 1", bus.err_o);
    end
  endtask

  task automatic test_reset_mid();
    bit   go_seen = 1'b0;
    logic [63:0] outs;
    pend[0] = 1; pend[1] = 1;
    push_blk(2'd0, 1'b0);
    drive_req();
    serve_block(0, 1'b0);
    for (int i = 0; i < 300 && !go_seen; i++) begin
      @(negedge clk);
      if (bus.rle_data_go_o) go_seen = 1'b1;
    end
    tests_run++;
    if (!go_seen || bus.comp_id_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL cb_go: seen=%b comp=%0d expected 1,1", go_seen, bus.comp_id_o);
    end
    repeat (31) @(negedge clk);
    tests_run++;
    if (bus.rle_data_o !== coeff(2'd1, 6'd30)) begin
      tests_failed++;
      $display("FAIL coeff_30_pre_reset: got %h expected %h", bus.rle_data_o, coeff(2'd1, 6'd30));
    end
    rst = 1'b1;
    #1;
    outs = {bus.blk_ack_o, bus.buf_rd_o, bus.buf_sel_o, bus.buf_addr_o, bus.rle_data_go_o,
            bus.rle_data_o, bus.rle_len_o, bus.comp_id_o, bus.mcu_done_o, bus.busy_o,
            bus.err_o, 21'd0};
    tests_run++;
    if (outs !== 64'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %h expected 0", outs);
    end
    err_exp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.blk_ack_o !== 3'b000) begin
        tests_failed++;
        $display("FAIL ack_in_reset: got %b expected 000", bus.blk_ack_o);
      end
    end
    rst = 1'b0;
    pend[0] = 1; pend[2] = 1;
    push_blk(2'd0, 1'b0); push_blk(2'd1, 1'b0); push_blk(2'd2, 1'b1);
    drive_req();
    for (int b = 0; b < 3; b++) serve_block(1, 1'b0);
  endtask

  task automatic test_len_bounds();
    for (int pass = 0; pass < 2; pass++) begin
      len_cfg[0] = (pass == 0) ? 6'd0 : 6'd63;
      len_cfg[1] = 6'd9; len_cfg[2] = 6'd33;
      pend[0] = 1; pend[1] = 1; pend[2] = 1;
      push_blk(2'd0, 1'b0); push_blk(2'd1, 1'b0); push_blk(2'd2, 1'b1);
      drive_req();
      for (int b = 0; b < 3; b++) serve_block(0, 1'b0);
    end
    expect_idle("idle_at_end");
  endtask

  initial begin
    bus.mode420_i  = 1'b0;
    bus.blk_req_i  = 3'b000;
    bus.blk_len_i  = '0;
    bus.dn_ready_i = 1'b1;
    bus.rle_last_i = 1'b0;
    pend[0] = 0; pend[1] = 0; pend[2] = 0;
    len_cfg[0] = '0; len_cfg[1] = '0; len_cfg[2] = '0;
    test_reset();
    test_mcu_444();
`ifdef SCHED_420_EN
    test_mcu_420();
`endif
    test_ready_stall();
    test_drain_timeout();
    test_reset_mid();
    test_len_bounds();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
